// File: rtl/m_006_pwm_pkg.sv
// Shared types and helpers for the PWM generator.
//   pwm_state_t : IDLE / ARM / RUN control states
//   cnt_max()   : last count value of a WIDTH-bit wrapping counter
package m_006_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } pwm_state_t;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/m_005_up_counter.sv
// Free-running up-counter that supplies the PWM generator's count.
// Ports:
//   clk_i   : clock, rising edge
//   n_rst_i : asynchronous active-low reset, clears the count
//   en_i    : count enable
//   cnt_o   : current count, wraps from 2**WIDTH-1 to 0
module m_005_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/m_006_pwm_gen.sv
// PWM generator: compares an external wrapping count against a
// double-buffered duty value and drives a registered PWM output plus a
// period-boundary pulse.
// Ports:
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous active-high reset
//   en_i          : enable request, sampled every cycle
//   cnt_i         : count from the up-counter (0..2**WIDTH-1, wraps)
//   duty_i        : requested high time in cycles (0..2**WIDTH)
//   duty_valid_i  : duty_i valid
//   duty_ready_o  : pending buffer empty, a new duty can be accepted
//   pwm_o         : registered PWM output
//   wrap_o        : one-cycle registered period-boundary pulse
//   active_duty_o : duty currently applied
module m_006_pwm_gen
    import m_006_pwm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH:0]   duty_i,
    input  logic             duty_valid_i,
    output logic             duty_ready_o,
    output logic             pwm_o,
    output logic             wrap_o,
    output logic [WIDTH:0]   active_duty_o
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

    pwm_state_t       state;
    pwm_state_t       state_next;
    logic [WIDTH:0]   pending_duty;
    logic             pending_empty;
    logic [WIDTH:0]   active_duty;
    logic             pwm_next;
    logic             wrap_next;
    logic             last;
    logic             accept;
    logic             transfer;

    assign last     = (cnt_i == MAX);
    assign accept   = duty_valid_i & pending_empty;
    // The pending flag is a flop, so a duty accepted on the last count is
    // not yet visible here and waits for the following period end.
    assign transfer = last & en_i & ~pending_empty &
                      ((state == ARM) || (state == RUN));

    always_comb begin
        state_next = state;
        pwm_next   = 1'b0;
        wrap_next  = last & en_i & (state != IDLE);
        case (state)
            IDLE: begin
                if (en_i) state_next = ARM;
            end
            ARM: begin
                if (!en_i)     state_next = IDLE;
                else if (last) state_next = RUN;
            end
            RUN: begin
                if (!en_i) begin
                    state_next = IDLE;
                end else begin
                    // Zero-extended compare so a duty of 2**WIDTH stays high
                    // across the wrap.
                    pwm_next = ({1'b0, cnt_i} < active_duty);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            pwm_o  <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            state  <= state_next;
            pwm_o  <= pwm_next;
            wrap_o <= wrap_next;
        end
    end

    // Double buffer: pending holds an accepted duty until a period end,
    // active holds the duty the comparator uses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_duty  <= '0;
            pending_empty <= 1'b1;
            active_duty   <= '0;
        end else begin
            if (transfer) begin
                active_duty   <= pending_duty;
                pending_empty <= 1'b1;
            end else if (accept) begin
                pending_duty  <= duty_i;
                pending_empty <= 1'b0;
            end
        end
    end

    assign duty_ready_o  = pending_empty;
    assign active_duty_o = active_duty;

endmodule

// File: tb/tb_m_006_pwm_gen.sv
module tb_m_006_pwm_gen;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] cnt;
    logic [W:0]   duty;
    logic         duty_valid;
    logic         duty_ready;
    logic         pwm;
    logic         wrap;
    logic [W:0]   active_duty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pwm;
        logic       wrap;
        logic       ready;
        logic [W:0] act;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int         m_state;
    logic [W:0] m_pend;
    logic       m_pend_vld;
    logic [W:0] m_act;
    logic [W-1:0] m_cnt;

    m_005_up_counter #(.WIDTH(W)) u_cnt (
        .clk_i   (clk),
        .n_rst_i (~rst),
        .en_i    (1'b1),
        .cnt_o   (cnt)
    );

    m_006_pwm_gen #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .cnt_i         (cnt),
        .duty_i        (duty),
        .duty_valid_i  (duty_valid),
        .duty_ready_o  (duty_ready),
        .pwm_o         (pwm),
        .wrap_o        (wrap),
        .active_duty_o (active_duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_pend     = '0;
        m_pend_vld = 1'b0;
        m_act      = '0;
        m_cnt      = '0;
    endtask

    // One clock: predict the post-edge outputs, push them, clock, pop and compare.
    task automatic step();
        exp_t e;
        exp_t o;
        logic last;
        logic xfer;
        last   = (m_cnt == W'((1 << W) - 1));
        xfer   = last && en && (m_state != 0) && m_pend_vld;
        e.pwm  = (m_state == 2) && en && ({1'b0, m_cnt} < m_act);
        e.wrap = last && en && (m_state != 0);
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 0; else if (last) m_state = 2;
            default: if (!en) m_state = 0;
        endcase
        if (xfer) begin
            m_act      = m_pend;
            m_pend_vld = 1'b0;
        end else if (duty_valid && !m_pend_vld) begin
            m_pend     = duty;
            m_pend_vld = 1'b1;
        end
        m_cnt   = m_cnt + 1'b1;
        e.ready = !m_pend_vld;
        e.act   = m_act;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            o = sb.pop_front();
            chk("cnt", 32'(cnt), 32'(o.cnt));
            chk("pwm", 32'(pwm), 32'(o.pwm));
            chk("wrap", 32'(wrap), 32'(o.wrap));
            chk("ready", 32'(duty_ready), 32'(o.ready));
            chk("active", 32'(active_duty), 32'(o.act));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the count about to be sampled equals v (bounded).
    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (m_cnt != W'(v) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("wait_cnt_timeout", 0, 1);
    endtask

    task automatic send_duty(input int d);
        duty       = (W+1)'(d);
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
    endtask

    // Count PWM highs and wrap pulses over one full period.
    task automatic count_period(input string tag, input int exp_high);
        int highs;
        int wraps;
        highs = 0;
        wraps = 0;
        for (int i = 0; i < (1 << W); i++) begin
            step();
            if (pwm === 1'b1) highs++;
            if (wrap === 1'b1) wraps++;
        end
        chk({tag, "_highs"}, 32'(highs), 32'(exp_high));
        chk({tag, "_wraps"}, 32'(wraps), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        duty       = '0;
        duty_valid = 1'b0;
        model_reset();
        #12;
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_ready", 32'(duty_ready), 1);
        chk("rst_active", 32'(active_duty), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // basic duty: accept 5 while idle, then enable
        steps(3);
        send_duty(5);
        en = 1'b1;
        wait_cnt(0);
        count_period("basic1", 5);
        count_period("basic2", 5);

        // double buffer: new duty mid-period; changes while not ready are ignored
        wait_cnt(3);
        send_duty(12);
        duty       = 5'd3;
        duty_valid = 1'b1;
        steps(3);
        duty_valid = 1'b0;
        wait_cnt(0);
        count_period("dbuf", 12);

        // simultaneous: accept on the last count, applies one period later
        wait_cnt(15);
        send_duty(8);
        count_period("simul_old", 12);
        count_period("simul_new", 8);

        // extremes
        send_duty(0);
        wait_cnt(0);
        count_period("duty0", 0);
        send_duty(16);
        wait_cnt(0);
        count_period("duty16a", 16);
        count_period("duty16b", 16);

        // disable mid-period, re-enable, retained duty resumes
        send_duty(5);
        wait_cnt(0);
        steps(16);
        wait_cnt(7);
        en = 1'b0;
        wait_cnt(10);
        en = 1'b1;
        wait_cnt(0);
        count_period("reen", 5);

        // async reset mid-RUN with pwm high
        wait_cnt(3);
        chk("pre_rst_pwm", 32'(pwm), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pwm", 32'(pwm), 0);
        chk("arst_wrap", 32'(wrap), 0);
        chk("arst_ready", 32'(duty_ready), 1);
        chk("arst_active", 32'(active_duty), 0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        steps(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m_006_pwm_gen.md
Name: m_006_pwm_gen

Overview:
- Downstream consumer of the free-running up-counter value. Compares the incoming count against a programmable duty value and produces a registered PWM output plus a period-boundary pulse.
- Duty updates arrive over a valid/ready handshake. They are double-buffered so a new duty takes effect only at a period boundary, which keeps the output glitch-free.
- Sits between the up-counter and any PWM-driven sink (LED and motor test logic).

Parameters:
- WIDTH, 4, width of the incoming count. The period is 2**WIDTH cycles (count runs 0..2**WIDTH-1, then wraps).

Ports:
- clk_i  input  1  clock; all logic is rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  enable request; sampled every cycle.
- cnt_i  input  WIDTH  count from the up-counter; increments by 1 per cycle and wraps.
- duty_i  input  WIDTH+1  requested high-time in cycles, 0..2**WIDTH.
- duty_valid_i  input  1  duty_i valid.
- duty_ready_o  output  1  pending buffer empty; a duty can be accepted.
- pwm_o  output  1  registered PWM output.
- wrap_o  output  1  one-cycle pulse, registered; marks a period boundary while the FSM is in ARM or RUN.
- active_duty_o  output  WIDTH+1  duty currently applied (debug/visibility).

Behaviour:
- Reset (async, rst_i=1): state=IDLE, pwm_o=0, wrap_o=0, active_duty_o=0, pending buffer emptied, so duty_ready_o=1. Reset mid-period discards the pending and active duty immediately.
- Definitions:
  - MAX = 2**WIDTH-1.
  - last = (cnt_i == MAX).
  - accept = duty_valid_i & duty_ready_o.
- Handshake:
  - duty_ready_o = ~pending_valid, driven from a flop.
  - On accept, pending <= duty_i and pending_valid <= 1.
  - duty_i may change freely when duty_ready_o=0 and has no effect.
  - Accepting is allowed in every state.
- Transfer:
  - Applies in the cycle where last=1 and state is ARM or RUN with en_i=1, and pending_valid=1.
  - Then active_duty <= pending and pending_valid <= 0, so duty_ready_o returns to 1 next cycle.
  - A value accepted in the same cycle as last is NOT transferred in that cycle. It waits for the next period end.
- FSM states:
  - IDLE: pwm_o=0, no wrap pulses. If en_i=1, go to ARM.
  - ARM: pwm_o=0. Waits to align to a period start. When last=1 & en_i=1, transfer pending if present and go to RUN. If en_i=0, go to IDLE.
  - RUN: pwm_o <= (cnt_i < active_duty), a 1-cycle registered latency, so pwm_o reflects the count from the previous cycle. If en_i=0, go to IDLE; pwm_o=0 from the next edge and the partial period is abandoned.
- wrap_o <= last & en_i & (state != IDLE).
- Comparison is unsigned, WIDTH+1 bits, with cnt_i zero-extended:
  - duty 0 gives constant low.
  - duty 2**WIDTH (or greater than MAX) gives constant high through the wrap.
  - duty k gives exactly k high cycles per period.
- active_duty persists across IDLE; only reset clears it.
- Re-enable always passes through ARM. The first RUN period starts with cnt_i=0.

Decomposition:
- Package m_006_pwm_pkg:
  - typedef enum logic [1:0] {IDLE, ARM, RUN} pwm_state_t.
  - function cnt_max(width) returning 2**width-1.
- No sub-module. Pending/active buffering is a few flops inline. The bench instantiates m_005_up_counter as the cnt_i source; note it uses n_rst_i, so drive it with ~rst_i.

Test Plan:
- Reset: assert rst_i mid-RUN with duty 5 active -> same cycle: pwm_o=0, wrap_o=0, active_duty_o=0, duty_ready_o=1.
- Basic duty (WIDTH=4): accept duty 5 while IDLE, en_i=1 -> ARM until cnt_i=15, then active_duty_o=5. In each following period pwm_o is high exactly 5 cycles (counts 0..4 seen one cycle late) and wrap_o pulses once every 16 cycles.
- Double buffer: in RUN with duty 5, accept duty 12 at cnt_i=3 -> duty_ready_o=0 until after cnt_i=15. The current period keeps 5 high cycles, the next has 12, then duty_ready_o=1.
- Simultaneous: accept duty 8 exactly when cnt_i=15 -> no transfer that cycle. The next period still uses the old duty; duty 8 applies one period later.
- Extremes: duty 0 -> pwm_o constant 0. Duty 16 -> pwm_o constant 1 across the wrap (no low glitch at cnt_i=0).
- Disable: drop en_i at cnt_i=7 in RUN -> pwm_o=0 from the next edge and wrap_o silent. Re-assert at cnt_i=10 -> ARM until cnt_i=15, then output resumes with the retained active_duty_o.
